// File: rtl/multicycle_control_fsm_if.sv
// Control/memory handshake bundle between the multicycle control FSM (master) and the datapath/memory side (slave).
// With MUL_EXT_EN defined the bundle also carries the multiplier start/done handshake.
interface multicycle_control_fsm_if #(
    parameter int unsigned ALUOP_W = 4
);
    logic [31:0]        instr;
    logic               imem_ready;
    logic               dmem_ready;
    logic               br_taken;
    logic               imem_req;
    logic               ir_we;
    logic               pc_we;
    logic               pc_sel;
    logic [ALUOP_W-1:0] ALUop;
    logic               BSel;
    logic               regWEn;
    logic [1:0]         memRW;
    logic [1:0]         WBsel;
    logic               illegal;
    logic               mem_fault;
`ifdef MUL_EXT_EN
    logic               mul_start;
    logic               mul_done;
`endif

    modport master (
`ifdef MUL_EXT_EN
        output mul_start,
        input  mul_done,
`endif
        input  instr, imem_ready, dmem_ready, br_taken,
        output imem_req, ir_we, pc_we, pc_sel, ALUop, BSel, regWEn, memRW, WBsel,
        output illegal, mem_fault
    );

    modport slave (
`ifdef MUL_EXT_EN
        input  mul_start,
        output mul_done,
`endif
        output instr, imem_ready, dmem_ready, br_taken,
        input  imem_req, ir_we, pc_we, pc_sel, ALUop, BSel, regWEn, memRW, WBsel,
        input  illegal, mem_fault
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32 control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes, timeout and sticky traps.
// Optional MUL_EXT_EN adds R-type func7 0000001 decode and a MULW wait state with mul_start/mul_done.
module multicycle_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned ALUOP_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_control_fsm_if.master bus
);

    localparam int unsigned CNT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam int unsigned TO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
    localparam bit          TO_EN   = (MEM_TIMEOUT != 0);

    typedef logic [ALUOP_W-1:0] aluop_t;
    localparam aluop_t ALU_ADD   = aluop_t'(4'h0);
    localparam aluop_t ALU_SUB   = aluop_t'(4'h1);
    localparam aluop_t ALU_AND   = aluop_t'(4'h2);
    localparam aluop_t ALU_OR    = aluop_t'(4'h3);
    localparam aluop_t ALU_XOR   = aluop_t'(4'h4);
    localparam aluop_t ALU_SLL   = aluop_t'(4'h5);
    localparam aluop_t ALU_SRL   = aluop_t'(4'h6);
    localparam aluop_t ALU_SRA   = aluop_t'(4'h7);
    localparam aluop_t ALU_SLT   = aluop_t'(4'h8);
    localparam aluop_t ALU_SLTU  = aluop_t'(4'h9);
    localparam aluop_t ALU_PASSB = aluop_t'(4'hA);
    localparam aluop_t ALU_BAD   = aluop_t'(4'hF);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
`ifdef MUL_EXT_EN
        , S_MULW
`endif
    } state_e;

    typedef enum logic [2:0] {
        C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL
`ifdef MUL_EXT_EN
        , C_MUL
`endif
    } cls_e;

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d, dec_cls;
    aluop_t           aluop_q, aluop_d, dec_aluop;
    logic             bsel_q, bsel_d, dec_bsel;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             fault_q, fault_d;
    logic             timeout;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       unused_instr;

    logic       imem_req_c, ir_we_c, pc_we_c, pc_sel_c, bsel_c, regwen_c;
    aluop_t     aluop_c;
    logic [1:0] memrw_c, wbsel_c;
`ifdef MUL_EXT_EN
    logic       mul_start_c;
`endif

    assign opcode       = bus.instr[6:0];
    assign func3        = bus.instr[14:12];
    assign func7        = bus.instr[31:25];
    assign unused_instr = ^{bus.instr[24:15], bus.instr[11:7]};
    assign timeout      = TO_EN && (cnt_q == CNT_W'(TO_LAST));

    // Instruction decode of the word on the imem bus; latched when the IR loads.
    always_comb begin
        dec_cls   = C_ALU;
        dec_aluop = ALU_BAD;
        dec_bsel  = 1'b0;
        case (opcode)
            OP_R: begin
                case (func7)
                    7'b0000000: begin
                        case (func3)
                            3'b000:  dec_aluop = ALU_ADD;
                            3'b001:  dec_aluop = ALU_SLL;
                            3'b010:  dec_aluop = ALU_SLT;
                            3'b011:  dec_aluop = ALU_SLTU;
                            3'b100:  dec_aluop = ALU_XOR;
                            3'b101:  dec_aluop = ALU_SRL;
                            3'b110:  dec_aluop = ALU_OR;
                            default: dec_aluop = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (func3 == 3'b000)      dec_aluop = ALU_SUB;
                        else if (func3 == 3'b101) dec_aluop = ALU_SRA;
                    end
`ifdef MUL_EXT_EN
                    7'b0000001: begin
                        dec_cls   = C_MUL;
                        dec_aluop = ALU_ADD;
                    end
`endif
                    default: dec_aluop = ALU_BAD;
                endcase
            end
            OP_I: begin
                dec_bsel = 1'b1;
                case (func3)
                    3'b000:  dec_aluop = ALU_ADD;
                    3'b001:  dec_aluop = (func7 == 7'b0000000) ? ALU_SLL : ALU_BAD;
                    3'b010:  dec_aluop = ALU_SLT;
                    3'b011:  dec_aluop = ALU_SLTU;
                    3'b100:  dec_aluop = ALU_XOR;
                    3'b101:  dec_aluop = (func7 == 7'b0000000) ? ALU_SRL :
                                         (func7 == 7'b0100000) ? ALU_SRA : ALU_BAD;
                    3'b110:  dec_aluop = ALU_OR;
                    default: dec_aluop = ALU_AND;
                endcase
            end
            OP_LOAD: begin
                dec_cls   = C_LOAD;
                dec_aluop = ALU_ADD;
                dec_bsel  = 1'b1;
            end
            OP_STORE: begin
                dec_cls   = C_STORE;
                dec_aluop = ALU_ADD;
                dec_bsel  = 1'b1;
            end
            OP_BRANCH: begin
                dec_cls   = C_BRANCH;
                dec_aluop = ALU_SUB;
            end
            OP_JAL: begin
                dec_cls   = C_JAL;
                dec_aluop = ALU_ADD;
                dec_bsel  = 1'b1;
            end
            OP_LUI: begin
                dec_aluop = ALU_PASSB;
                dec_bsel  = 1'b1;
            end
            default: dec_aluop = ALU_BAD;
        endcase
    end

    // State and decode-field register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_BOOT;
            cls_q     <= C_ALU;
            aluop_q   <= '0;
            bsel_q    <= 1'b0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            aluop_q   <= aluop_d;
            bsel_q    <= bsel_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
        end
    end

    // Next state; the wait counter restarts on every state entry and ready beats expiry.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        aluop_d   = aluop_q;
        bsel_d    = bsel_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ready) begin
                    state_d = S_DECODE;
                    cls_d   = dec_cls;
                    aluop_d = dec_aluop;
                    bsel_d  = dec_bsel;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (aluop_q == ALU_BAD) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BRANCH:        state_d = S_FETCH;
`ifdef MUL_EXT_EN
                    C_MUL:           state_d = S_MULW;
`endif
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.dmem_ready) begin
                    state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB:   state_d = S_FETCH;
`ifdef MUL_EXT_EN
            S_MULW: if (bus.mul_done) state_d = S_WB;
`endif
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_BOOT;
        endcase
    end

    // Datapath controls from state and latched decode; WBsel idles at "none" outside BOOT/TRAP.
    always_comb begin
        imem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = 1'b0;
        aluop_c    = '0;
        bsel_c     = 1'b0;
        regwen_c   = 1'b0;
        memrw_c    = 2'b00;
        wbsel_c    = 2'b11;
`ifdef MUL_EXT_EN
        mul_start_c = 1'b0;
`endif
        case (state_q)
            S_BOOT, S_TRAP: wbsel_c = 2'b00;
            S_FETCH: begin
                imem_req_c = 1'b1;
                ir_we_c    = bus.imem_ready;
            end
            S_EXEC: begin
                aluop_c = aluop_q;
                bsel_c  = bsel_q;
                case (cls_q)
                    C_BRANCH: begin
                        pc_we_c  = 1'b1;
                        pc_sel_c = bus.br_taken;
                    end
                    C_JAL: begin
                        pc_we_c  = 1'b1;
                        pc_sel_c = 1'b1;
                    end
`ifdef MUL_EXT_EN
                    C_MUL:   mul_start_c = 1'b1;
`endif
                    default: ;
                endcase
            end
            S_MEM: begin
                aluop_c = aluop_q;
                bsel_c  = bsel_q;
                if (cls_q == C_LOAD) begin
                    memrw_c = 2'b01;
                    wbsel_c = 2'b00;
                end else begin
                    memrw_c = 2'b10;
                    pc_we_c = bus.dmem_ready;
                end
            end
            S_WB: begin
                aluop_c  = aluop_q;
                bsel_c   = bsel_q;
                regwen_c = 1'b1;
                pc_we_c  = (cls_q != C_JAL);
                case (cls_q)
                    C_LOAD:  wbsel_c = 2'b00;
                    C_JAL:   wbsel_c = 2'b10;
                    default: wbsel_c = 2'b01;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.imem_req  = imem_req_c;
    assign bus.ir_we     = ir_we_c;
    assign bus.pc_we     = pc_we_c;
    assign bus.pc_sel    = pc_sel_c;
    assign bus.ALUop     = aluop_c;
    assign bus.BSel      = bsel_c;
    assign bus.regWEn    = regwen_c;
    assign bus.memRW     = memrw_c;
    assign bus.WBsel     = wbsel_c;
    assign bus.illegal   = illegal_q;
    assign bus.mem_fault = fault_q;
`ifdef MUL_EXT_EN
    assign bus.mul_start = mul_start_c;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle control vectors for each instruction class, traps and timeout.
module tb_multicycle_control_fsm;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.ALUOP_W(4)) bus ();

    multicycle_control_fsm #(.MEM_TIMEOUT(15), .ALUOP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // Vector order: imem_req ir_we pc_we pc_sel ALUop[3:0] BSel regWEn memRW[1:0] WBsel[1:0]
    task automatic expect_o(input string tag, input logic req, input logic irwe, input logic pcwe,
                            input logic pcsel, input logic [3:0] alu, input logic bsel, input logic rwen,
                            input logic [1:0] mrw, input logic [1:0] wbs);
        logic [13:0] exp_v, obs_v;
        exp_v = {req, irwe, pcwe, pcsel, alu, bsel, rwen, mrw, wbs};
        obs_v = {bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_sel, bus.ALUop, bus.BSel, bus.regWEn,
                 bus.memRW, bus.WBsel};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs_v, exp_v);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp_b);
        checks++;
        assert (obs === exp_b) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_b);
        end
    endtask

    // From a FETCH cycle: fetch with ready, check DECODE, end at the start of EXEC.
    task automatic fetch_ok(input string tag, input logic [31:0] word);
        bus.instr      = word;
        bus.imem_ready = 1'b1;
        settle();
        expect_o({tag, "_fetch"}, 1, 1, 0, 0, 4'h0, 0, 0, 2'b00, 2'b11);
        tick();
        bus.imem_ready = 1'b0;
        settle();
        expect_o({tag, "_decode"}, 0, 0, 0, 0, 4'h0, 0, 0, 2'b00, 2'b11);
        tick();
    endtask

    task automatic run_alu(input string tag, input logic [31:0] word, input logic [3:0] alu, input logic bsel);
        fetch_ok(tag, word);
        settle();
        expect_o({tag, "_exec"}, 0, 0, 0, 0, alu, bsel, 0, 2'b00, 2'b11);
        tick();
        settle();
        expect_o({tag, "_wb"}, 0, 0, 1, 0, alu, bsel, 1, 2'b00, 2'b01);
        tick();
    endtask

    // Reset pulse; returns at the start of the first FETCH cycle.
    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        expect_o("rst_boot", 0, 0, 0, 0, 4'h0, 0, 0, 2'b00, 2'b00);
        chk_bit("rst_illegal", bus.illegal, 1'b0);
        chk_bit("rst_fault", bus.mem_fault, 1'b0);
        tick();
    endtask

    initial begin
        rst            = 1'b1;
        bus.instr      = 32'h0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.br_taken   = 1'b0;
`ifdef MUL_EXT_EN
        bus.mul_done   = 1'b0;
`endif
        do_reset();

        // ALU-class instructions: 4 cycles each
        run_alu("add",  32'h002081B3, 4'h0, 1'b0);
        run_alu("sltu", 32'h0020B1B3, 4'h9, 1'b0);
        run_alu("srai", 32'h4020D193, 4'h7, 1'b1);
        run_alu("or",   32'h0020E1B3, 4'h3, 1'b0);
        run_alu("lui",  32'h123450B7, 4'hA, 1'b1);
        run_alu("sub",  32'h402081B3, 4'h1, 1'b0);
        run_alu("addi", 32'h00508093, 4'h0, 1'b1);

        // LW with dmem_ready 3 cycles late
        fetch_ok("lw", 32'h0000A183);
        settle();
        expect_o("lw_exec", 0, 0, 0, 0, 4'h0, 1, 0, 2'b00, 2'b11);
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            expect_o("lw_mem_wait", 0, 0, 0, 0, 4'h0, 1, 0, 2'b01, 2'b00);
            tick();
        end
        bus.dmem_ready = 1'b1;
        settle();
        expect_o("lw_mem_ready", 0, 0, 0, 0, 4'h0, 1, 0, 2'b01, 2'b00);
        tick();
        bus.dmem_ready = 1'b0;
        settle();
        expect_o("lw_wb", 0, 0, 1, 0, 4'h0, 1, 1, 2'b00, 2'b00);
        tick();

        // SW: pc_we only on the ready cycle of MEM, no write-back
        fetch_ok("sw", 32'h0020A023);
        settle();
        expect_o("sw_exec", 0, 0, 0, 0, 4'h0, 1, 0, 2'b00, 2'b11);
        tick();
        settle();
        expect_o("sw_mem_wait", 0, 0, 0, 0, 4'h0, 1, 0, 2'b10, 2'b11);
        tick();
        bus.dmem_ready = 1'b1;
        settle();
        expect_o("sw_mem_ready", 0, 0, 1, 0, 4'h0, 1, 0, 2'b10, 2'b11);
        tick();
        bus.dmem_ready = 1'b0;
        settle();
        expect_o("sw_next_fetch", 1, 0, 0, 0, 4'h0, 0, 0, 2'b00, 2'b11);

        // BEQ taken then not taken: EXEC goes straight back to FETCH
        fetch_ok("beq_t", 32'h00208463);
        bus.br_taken = 1'b1;
        settle();
        expect_o("beq_t_exec", 0, 0, 1, 1, 4'h1, 0, 0, 2'b00, 2'b11);
        tick();
        bus.br_taken = 1'b0;
        settle();
        expect_o("beq_t_next_fetch", 1, 0, 0, 0, 4'h0, 0, 0, 2'b00, 2'b11);
        fetch_ok("beq_n", 32'h00208463);
        settle();
        expect_o("beq_n_exec", 0, 0, 1, 0, 4'h1, 0, 0, 2'b00, 2'b11);
        tick();

        // JAL: PC updated in EXEC, WB writes pc+4 without a second PC pulse
        fetch_ok("jal", 32'h008000EF);
        settle();
        expect_o("jal_exec", 0, 0, 1, 1, 4'h0, 1, 0, 2'b00, 2'b11);
        tick();
        settle();
        expect_o("jal_wb", 0, 0, 0, 0, 4'h0, 1, 1, 2'b00, 2'b10);
        tick();

        // Reset in the middle of a load aborts it
        fetch_ok("lw_abort", 32'h0000A183);
        tick();
        rst            = 1'b1;
        bus.dmem_ready = 1'b1;
        settle();
        expect_o("abort_mem", 0, 0, 0, 0, 4'h0, 1, 0, 2'b01, 2'b00);
        tick();
        rst            = 1'b0;
        bus.dmem_ready = 1'b0;
        settle();
        expect_o("abort_boot", 0, 0, 0, 0, 4'h0, 0, 0, 2'b00, 2'b00);
        tick();
        settle();
        expect_o("abort_fetch", 1, 0, 0, 0, 4'h0, 0, 0, 2'b00, 2'b11);

        // Undefined opcode: sticky TRAP until reset
        fetch_ok("bad_op", 32'h0000007F);
        settle();
        expect_o("bad_op_trap", 0, 0, 0, 0, 4'h0, 0, 0, 2'b00, 2'b00);
        chk_bit("bad_op_illegal", bus.illegal, 1'b1);
        bus.imem_ready = 1'b1;
        tick();
        settle();
        expect_o("bad_op_trap_hold", 0, 0, 0, 0, 4'h0, 0, 0, 2'b00, 2'b00);
        chk_bit("bad_op_illegal_hold", bus.illegal, 1'b1);
        chk_bit("bad_op_no_fault", bus.mem_fault, 1'b0);
        bus.imem_ready = 1'b0;
        do_reset();

        // R-type func7 0100000 with func3 111 is not a legal encoding
        fetch_ok("bad_f7", 32'h4020F1B3);
        settle();
        chk_bit("bad_f7_illegal", bus.illegal, 1'b1);
        do_reset();

        // MUL: multiplier handshake when enabled, otherwise illegal
`ifdef MUL_EXT_EN
        fetch_ok("mul", 32'h022081B3);
        settle();
        chk_bit("mul_start_exec", bus.mul_start, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk_bit("mul_start_wait", bus.mul_start, 1'b0);
            expect_o("mul_wait", 0, 0, 0, 0, 4'h0, 0, 0, 2'b00, 2'b11);
            tick();
        end
        bus.mul_done = 1'b1;
        tick();
        bus.mul_done = 1'b0;
        settle();
        expect_o("mul_wb", 0, 0, 1, 0, 4'h0, 0, 1, 2'b00, 2'b01);
        tick();
        do_reset();
`else
        fetch_ok("mul", 32'h022081B3);
        settle();
        expect_o("mul_trap", 0, 0, 0, 0, 4'h0, 0, 0, 2'b00, 2'b00);
        chk_bit("mul_illegal", bus.illegal, 1'b1);
        do_reset();
`endif

        // imem_ready withheld 15 cycles -> mem_fault
        for (int i = 0; i < 15; i++) begin
            settle();
            expect_o("to_fetch_wait", 1, 0, 0, 0, 4'h0, 0, 0, 2'b00, 2'b11);
            chk_bit("to_no_fault_yet", bus.mem_fault, 1'b0);
            tick();
        end
        settle();
        expect_o("to_trap", 0, 0, 0, 0, 4'h0, 0, 0, 2'b00, 2'b00);
        chk_bit("to_fault", bus.mem_fault, 1'b1);
        chk_bit("to_not_illegal", bus.illegal, 1'b0);
        do_reset();

        // Ready on the 15th FETCH cycle still succeeds
        for (int i = 0; i < 14; i++) tick();
        run_alu("late", 32'h002081B3, 4'h0, 1'b0);
        chk_bit("late_no_fault", bus.mem_fault, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
